// File: rtl/level_alarm_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : level_alarm_ctrl
// Description : Hysteretic level alarm. It raises the alarm after ON_COUNT
//               consecutive block peaks at or above the high threshold and
//               releases it after HOLD_BLOCKS consecutive blocks below the
//               effective low threshold.
// Revision    : 1.0 - initial release
//==============================================================================
module level_alarm_ctrl #(
    parameter int ON_COUNT    = 3,
    parameter int HOLD_BLOCKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] thresh_hi,
    input  logic [15:0] thresh_lo,
    input  logic [15:0] level,
    input  logic        level_ready,
    output logic [15:0] det_threshold,
    output logic        alarm,
    output logic        alarm_rise,
    output logic        alarm_fall,
    output logic [15:0] peak_hold,
    output logic [1:0]  state,
    output logic        cfg_err
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARMED   = 2'd1;
    localparam logic [1:0] c_ST_ALARM   = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

    localparam logic [7:0] c_ON_COUNT    = 8'(ON_COUNT);
    localparam logic [7:0] c_HOLD_BLOCKS = 8'(HOLD_BLOCKS);

    logic [1:0]  r_state,   w_state_nxt;
    logic [7:0]  r_hit_cnt, w_hit_cnt_nxt;
    logic [7:0]  r_rel_cnt, w_rel_cnt_nxt;
    logic        r_alarm,   w_alarm_nxt;
    logic        r_rise,    w_rise_nxt;
    logic        r_fall,    w_fall_nxt;
    logic [15:0] r_peak,    w_peak_nxt;
    logic [15:0] r_det_thr, w_det_thr_nxt;
    logic        r_cfg_err;

    logic [15:0] w_lo_eff;
    logic [15:0] w_peak_max;
    logic        w_hit;
    logic        w_miss;

    // A misconfigured low threshold is clamped so hysteresis never inverts.
    assign w_lo_eff   = (thresh_lo > thresh_hi) ? thresh_hi : thresh_lo;
    assign w_hit      = (level >= thresh_hi);
    assign w_miss     = (level < w_lo_eff);
    assign w_peak_max = (level > r_peak) ? level : r_peak;

    always_comb begin
        w_state_nxt   = r_state;
        w_hit_cnt_nxt = r_hit_cnt;
        w_rel_cnt_nxt = r_rel_cnt;
        w_alarm_nxt   = r_alarm;
        w_rise_nxt    = 1'b0;
        w_fall_nxt    = 1'b0;
        w_peak_nxt    = r_peak;

        if (r_state != c_ST_IDLE && !enable) begin
            w_state_nxt   = c_ST_IDLE;
            w_hit_cnt_nxt = 8'd0;
            w_rel_cnt_nxt = 8'd0;
            w_alarm_nxt   = 1'b0;
            w_fall_nxt    = r_alarm;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (enable) begin
                        w_state_nxt   = c_ST_ARMED;
                        w_hit_cnt_nxt = 8'd0;
                        w_rel_cnt_nxt = 8'd0;
                    end
                end
                c_ST_ARMED: begin
                    if (level_ready) begin
                        if (!w_hit) begin
                            w_hit_cnt_nxt = 8'd0;
                        end else if (r_hit_cnt + 8'd1 == c_ON_COUNT) begin
                            w_state_nxt   = c_ST_ALARM;
                            w_hit_cnt_nxt = 8'd0;
                            w_alarm_nxt   = 1'b1;
                            w_rise_nxt    = 1'b1;
                            w_peak_nxt    = level;
                        end else begin
                            w_hit_cnt_nxt = r_hit_cnt + 8'd1;
                        end
                    end
                end
                c_ST_ALARM: begin
                    if (level_ready) begin
                        w_peak_nxt = w_peak_max;
                        if (w_miss) begin
                            if (c_HOLD_BLOCKS == 8'd1) begin
                                w_state_nxt   = c_ST_ARMED;
                                w_rel_cnt_nxt = 8'd0;
                                w_alarm_nxt   = 1'b0;
                                w_fall_nxt    = 1'b1;
                            end else begin
                                w_state_nxt   = c_ST_RELEASE;
                                w_rel_cnt_nxt = 8'd1;
                            end
                        end
                    end
                end
                c_ST_RELEASE: begin
                    if (level_ready) begin
                        if (!w_miss) begin
                            w_state_nxt   = c_ST_ALARM;
                            w_rel_cnt_nxt = 8'd0;
                            w_peak_nxt    = w_peak_max;
                        end else if (r_rel_cnt + 8'd1 == c_HOLD_BLOCKS) begin
                            w_state_nxt   = c_ST_ARMED;
                            w_rel_cnt_nxt = 8'd0;
                            w_alarm_nxt   = 1'b0;
                            w_fall_nxt    = 1'b1;
                        end else begin
                            w_rel_cnt_nxt = r_rel_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end

        // The detector threshold follows the state being entered.
        if (w_state_nxt == c_ST_ALARM || w_state_nxt == c_ST_RELEASE) begin
            w_det_thr_nxt = w_lo_eff;
        end else begin
            w_det_thr_nxt = thresh_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_hit_cnt <= 8'd0;
            r_rel_cnt <= 8'd0;
            r_alarm   <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_peak    <= 16'd0;
            r_det_thr <= 16'd0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hit_cnt <= w_hit_cnt_nxt;
            r_rel_cnt <= w_rel_cnt_nxt;
            r_alarm   <= w_alarm_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            r_peak    <= w_peak_nxt;
            r_det_thr <= w_det_thr_nxt;
            r_cfg_err <= (thresh_lo > thresh_hi);
        end
    end

    assign det_threshold = r_det_thr;
    assign alarm         = r_alarm;
    assign alarm_rise    = r_rise;
    assign alarm_fall    = r_fall;
    assign peak_hold     = r_peak;
    assign state         = r_state;
    assign cfg_err       = r_cfg_err;

endmodule
`default_nettype wire
